inst_uncached_resp: RTL and testbench
=====================================

INST_UNCACHED_RESP -- requirements
Module: inst_uncached_resp

Interface
REQ-001 The block SHALL have the following ports; reset is synchronous, active-high, and the clock is clk.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  fetch stage requests an uncached instruction word.
- req_addr  in  32  physical fetch address, word aligned.
- accept  in  1  fetch stage consumes the presented word this cycle.
- flush  in  1  exception flush; cancels the current request.
- inst_valid  out  1  word is available on inst_data.
- inst_data  out  32  instruction word.
- inst_err  out  1  bus error for the presented word.
- ar_valid  out  1  read address valid.
- ar_ready  in  1  read address ready.
- ar_addr  out  32  read address.
- r_valid  in  1  read data valid.
- r_ready  out  1  read data ready.
- r_data  in  32  read data.
- r_resp  in  2  read response.

Function
REQ-002 The FSM SHALL have exactly five states: IDLE, ADDR, DATA, HOLD, DRAIN.
REQ-003 IDLE: when req=1 and flush=0, latch req_addr into addr_q and go to ADDR in the next cycle.
REQ-004 ADDR:
- ar_valid=1 and ar_addr=addr_q.
- When ar_ready=1, go to DATA.
- ar_valid SHALL NOT drop before the handshake completes.
- ar_addr SHALL stay stable while ar_valid=1.
REQ-005 DATA:
- r_ready=1.
- When r_valid=1, latch r_data into data_q and set err_q=(r_resp!=0), then go to HOLD.
REQ-006 HOLD:
- inst_valid=1, inst_data=data_q, inst_err=err_q.
- When accept=1, go to IDLE.
- inst_data SHALL stay constant while in HOLD.
REQ-007 Minimum latency SHALL be 3 cycles from req sampled in IDLE to inst_valid=1, with ar_ready and r_valid both high on first assertion.
REQ-008 Only one outstanding read is allowed; a new ADDR phase SHALL NOT start until the prior R beat has completed.
REQ-009 flush in IDLE or HOLD SHALL go to IDLE next cycle; inst_valid SHALL be 0 in the following cycle.
REQ-010 flush in ADDR: ar_valid SHALL stay high until ar_ready, then go to DRAIN. If flush and ar_ready coincide, the next state SHALL be DRAIN.
REQ-011 flush in DATA: go to DRAIN. If r_valid is high in the same cycle, discard the beat and go to IDLE.
REQ-012 DRAIN:
- r_ready=1.
- On r_valid, discard the data and go to IDLE.
- inst_valid SHALL stay 0 throughout.
REQ-013 A flush arriving while in DRAIN SHALL have no additional effect.
REQ-014 In HOLD, if req=1 and req_addr!=addr_q (stale word), go to IDLE without asserting inst_valid in the next cycle; the new request is taken from IDLE.
REQ-015 accept while inst_valid=0 SHALL be ignored.
REQ-016 inst_valid SHALL be combinational from state only: 1 iff state=HOLD.
REQ-017 ar_valid and r_ready SHALL be combinational from state only, never from AXI inputs.
REQ-018 r_valid outside DATA/DRAIN is a protocol violation; its behaviour is unspecified, and the block SHALL stay in its current state.

Reset
REQ-019 Reset SHALL place the FSM in IDLE; outputs inst_valid=0, ar_valid=0, r_ready=0.
REQ-020 Reset SHALL clear addr_q to 32'hbfc00000; data_q and err_q SHALL reset to 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction without draining; the interconnect is reset in the same cycle.

Structure
REQ-022 The shared CPU package SHALL hold:
- the state enum (IDLE, ADDR, DATA, HOLD, DRAIN);
- RESP_OKAY=2'b00;
- RESET_VECTOR=32'hbfc00000.
REQ-023 The block SHALL be a single module with no sub-modules and one registered FSM plus datapath registers.

Verification
REQ-024 Basic fetch: req, req_addr=0xbfc00000; ar_ready=1 immediately; r_valid with r_data=0x3c08bfc0 one cycle later -> inst_valid=1 with inst_data=0x3c08bfc0 exactly 3 cycles after req; inst_err=0.
REQ-025 Backpressure: ar_ready held low for 4 cycles, then accept held low for 5 cycles -> ar_addr stays constant, inst_data stays constant in HOLD, exactly one AR handshake.
REQ-026 Flush in DATA: flush while waiting for R; r_valid arrives 2 cycles later with 0xdeadbeef -> beat is consumed in DRAIN, inst_valid never asserts; next req to 0x80001000 returns its own data.
REQ-027 Error response: r_resp=2'b10 -> inst_valid=1 with inst_err=1; accept returns the FSM to IDLE.
REQ-028 Stale address: in HOLD for 0x80000000, req_addr changes to 0x80000040 -> IDLE next cycle; the new AR carries 0x80000040.
REQ-029 Reset during DATA -> IDLE next cycle; ar_valid=0, r_ready=0, inst_valid=0.

Source files
------------

// File: rtl/inst_uncached_resp_pkg.sv
// Shared CPU package for the uncached instruction-fetch responder.
// Holds the fetch FSM state encoding, the AXI OKAY response code, the
// boot reset vector and a small helper that classifies a read response.
package inst_uncached_resp_pkg;

  // Fetch FSM states; explicit encodings keep waveforms stable across builds.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

  // Any response other than OKAY is reported to fetch as a bus error.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/inst_uncached_resp.sv
// Uncached instruction-fetch responder.
// Turns a single fetch request into one AXI read (AR then R), holds the
// returned word for the fetch stage until it is accepted, and cleanly
// retires the read when an exception flush cancels the request.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, req_addr         fetch request and word-aligned physical address
//   accept                fetch stage consumes the presented word
//   flush                 exception flush, cancels the current request
//   inst_valid/data/err   presented instruction word and its bus-error flag
//   ar_valid/ready/addr   AXI read-address channel
//   r_valid/ready/data/resp  AXI read-data channel
module inst_uncached_resp
  import inst_uncached_resp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] req_addr,
  input  logic        accept,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic        inst_err,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [31:0] ar_addr,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;
  logic [31:0]  addr_q;
  logic [31:0]  data_q;
  logic         err_q;
  // A flush seen while the AR handshake is still pending; the address must
  // stay valid until ready, so the cancel is remembered and applied later.
  logic         flush_pend_r;
  logic         take_req_s;
  logic         take_beat_s;

  assign take_req_s  = (state_r == IDLE) && req && !flush;
  assign take_beat_s = (state_r == DATA) && r_valid && !flush;

  // Next-state decode for the fetch FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_req_s) begin
          state_next_s = ADDR;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADDR: begin
        if (ar_ready) begin
          if (flush || flush_pend_r) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = ADDR;
        end
      end
      DATA: begin
        if (flush) begin
          // A beat arriving with the flush retires the read immediately.
          if (r_valid) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DRAIN;
          end
        end else if (r_valid) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = DATA;
        end
      end
      HOLD: begin
        // A request for a different address means the held word is stale.
        if (flush || accept || (req && (req_addr != addr_q))) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      DRAIN: begin
        if (r_valid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Flush-pending flag, live only while the address phase is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pend_r <= 1'b0;
    end else if ((state_r == ADDR) && !ar_ready) begin
      flush_pend_r <= flush_pend_r || flush;
    end else begin
      flush_pend_r <= 1'b0;
    end
  end

  // Request address capture; held for the whole transaction so AR is stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= RESET_VECTOR;
    end else if (take_req_s) begin
      addr_q <= req_addr;
    end
  end

  // Read-beat capture; only a non-cancelled beat in DATA is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= 32'h0000_0000;
      err_q  <= 1'b0;
    end else if (take_beat_s) begin
      data_q <= r_data;
      err_q  <= resp_is_error(r_resp);
    end
  end

  // Handshake outputs decode from the state register only.
  assign inst_valid = (state_r == HOLD);
  assign ar_valid   = (state_r == ADDR);
  assign r_ready    = (state_r == DATA) || (state_r == DRAIN);
  assign ar_addr    = addr_q;
  assign inst_data  = data_q;
  assign inst_err   = err_q;

endmodule

// File: tb/tb_inst_uncached_resp.sv
// Self-checking bench for inst_uncached_resp: directed scenarios followed by
// a randomized run, all compared against a transaction-level reference model
// (pending-address / pending-read / held-word flags) and a simple AXI slave.
module tb_inst_uncached_resp;

  logic        clk = 1'b0;
  logic        reset, req, accept, flush, ar_ready, r_valid;
  logic [31:0] req_addr, r_data;
  logic [1:0]  r_resp;
  logic        inst_valid, inst_err, ar_valid, r_ready;
  logic [31:0] inst_data, ar_addr;

  int checks = 0;
  int errors = 0;
  int arHs   = 0;

  // Reference model: what the block is waiting for, independent of encoding.
  logic        mArBusy, mRBusy, mCancel, mWordValid, mErr;
  logic [31:0] mAddr, mData;
  // Bench AXI slave: one outstanding read at most.
  logic        slvPend;
  logic [31:0] slvAddr;

  inst_uncached_resp dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .accept(accept), .flush(flush), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_err(inst_err), .ar_valid(ar_valid),
    .ar_ready(ar_ready), .ar_addr(ar_addr), .r_valid(r_valid),
    .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c08_5a5a;
  endfunction

  task automatic modelUpdate();
    if (reset) slvPend = 1'b0;
    else if (slvPend && r_valid) slvPend = 1'b0;
    else if (mArBusy && ar_ready) begin
      slvPend = 1'b1;
      slvAddr = mAddr;
    end

    if (reset) begin
      mArBusy = 1'b0; mRBusy = 1'b0; mCancel = 1'b0; mWordValid = 1'b0;
      mAddr = 32'hbfc00000; mData = 32'h0; mErr = 1'b0;
    end else if (mWordValid) begin
      if (flush || accept || (req && (req_addr != mAddr))) mWordValid = 1'b0;
    end else if (mArBusy) begin
      if (flush) mCancel = 1'b1;
      if (ar_ready) begin
        mArBusy = 1'b0;
        mRBusy  = 1'b1;
      end
    end else if (mRBusy) begin
      if (r_valid) begin
        mRBusy = 1'b0;
        if (!flush && !mCancel) begin
          mWordValid = 1'b1;
          mData      = r_data;
          mErr       = (r_resp != 2'b00);
        end
        mCancel = 1'b0;
      end else if (flush) begin
        mCancel = 1'b1;
      end
    end else if (req && !flush) begin
      mArBusy = 1'b1;
      mAddr   = req_addr;
    end
  endtask

  // One clock: inputs already set; model follows the edge, outputs checked at negedge.
  task automatic step();
    if (ar_valid && ar_ready) arHs++;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkVal("inst_valid", {31'b0, inst_valid}, {31'b0, mWordValid});
    checkVal("ar_valid", {31'b0, ar_valid}, {31'b0, mArBusy});
    checkVal("r_ready", {31'b0, r_ready}, {31'b0, mRBusy});
    if (mArBusy) checkVal("ar_addr", ar_addr, mAddr);
    if (mWordValid) begin
      checkVal("inst_data", inst_data, mData);
      checkVal("inst_err", {31'b0, inst_err}, {31'b0, mErr});
    end
  endtask

  task automatic clrIn();
    reset = 1'b0; req = 1'b0; accept = 1'b0; flush = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = 32'h0; r_resp = 2'b00;
  endtask

  task automatic doReset();
    clrIn();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Drive one fetch to HOLD with immediate handshakes.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs);
    req = 1'b1; req_addr = a; step();
    req = 1'b0; ar_ready = 1'b1; step();
    ar_ready = 1'b0; r_valid = 1'b1; r_data = d; r_resp = rs; step();
    r_valid = 1'b0; r_resp = 2'b00;
  endtask

  initial begin
    logic [31:0] curAddr;
    clrIn();
    req_addr = 32'h0;
    mArBusy = 1'b0; mRBusy = 1'b0; mCancel = 1'b0; mWordValid = 1'b0;
    mAddr = 32'h0; mData = 32'h0; mErr = 1'b0; slvPend = 1'b0; slvAddr = 32'h0;
    @(negedge clk);

    // Reset state.
    doReset();
    checkVal("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkVal("rst_ar_valid", {31'b0, ar_valid}, 32'd0);
    checkVal("rst_r_ready", {31'b0, r_ready}, 32'd0);

    // Basic fetch: word presented exactly 3 cycles after req.
    fetch(32'hbfc00000, 32'h3c08bfc0, 2'b00);
    checkVal("basic_valid", {31'b0, inst_valid}, 32'd1);
    checkVal("basic_data", inst_data, 32'h3c08bfc0);
    checkVal("basic_err", {31'b0, inst_err}, 32'd0);
    accept = 1'b1; step(); accept = 1'b0;

    // Backpressure on AR and on accept; exactly one AR handshake.
    arHs = 0;
    req = 1'b1; req_addr = 32'h80000000; step(); req = 1'b0;
    repeat (4) begin
      step();
      checkVal("bp_ar_addr", ar_addr, 32'h80000000);
    end
    ar_ready = 1'b1; step(); ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'h12345678; step(); r_valid = 1'b0;
    repeat (5) begin
      step();
      checkVal("bp_hold_data", inst_data, 32'h12345678);
    end
    accept = 1'b1; step(); accept = 1'b0;
    checkVal("bp_ar_handshakes", arHs, 32'd1);

    // Flush in DATA: late beat is drained, next fetch gets its own data.
    req = 1'b1; req_addr = 32'h80000800; step(); req = 1'b0;
    ar_ready = 1'b1; step(); ar_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    checkVal("fl_drain_r_ready", {31'b0, r_ready}, 32'd1);
    step();
    r_valid = 1'b1; r_data = 32'hdeadbeef; step(); r_valid = 1'b0;
    checkVal("fl_no_valid", {31'b0, inst_valid}, 32'd0);
    fetch(32'h80001000, 32'h24001000, 2'b00);
    checkVal("fl_next_data", inst_data, 32'h24001000);
    accept = 1'b1; step(); accept = 1'b0;

    // Error response.
    fetch(32'h80000010, 32'h00000000, 2'b10);
    checkVal("err_flag", {31'b0, inst_err}, 32'd1);
    accept = 1'b1; step(); accept = 1'b0;
    checkVal("err_accept_idle", {31'b0, inst_valid}, 32'd0);

    // Stale address in HOLD.
    fetch(32'h80000000, 32'h11110000, 2'b00);
    req = 1'b1; req_addr = 32'h80000040; step();
    checkVal("stale_no_valid", {31'b0, inst_valid}, 32'd0);
    step(); req = 1'b0;
    checkVal("stale_ar_addr", ar_addr, 32'h80000040);
    ar_ready = 1'b1; step(); ar_ready = 1'b0;

    // Reset during DATA abandons the read.
    reset = 1'b1; step(); reset = 1'b0;
    checkVal("rstd_ar_valid", {31'b0, ar_valid}, 32'd0);
    checkVal("rstd_r_ready", {31'b0, r_ready}, 32'd0);
    checkVal("rstd_inst_valid", {31'b0, inst_valid}, 32'd0);

    // Randomized run against the reference model.
    curAddr = 32'h80000000;
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom % 200) == 0;
      flush    = ($urandom % 16) == 0;
      accept   = ($urandom % 3) == 0;
      if (($urandom % 6) == 0) curAddr = 32'h80000000 + 32'($urandom_range(0, 3)) * 32'h40;
      req      = ($urandom % 2) == 0;
      req_addr = curAddr;
      ar_ready = ($urandom % 2) == 0;
      r_valid  = slvPend && (($urandom % 3) == 0);
      r_data   = memWord(slvAddr);
      r_resp   = (($urandom % 6) == 0) ? 2'b10 : 2'b00;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
